// File: rtl/apb_led_pwm.sv
// apb_led_pwm: APB3 slave driving NUM_LED PWM outputs with a shared prescaler
// and period counter.
//
// Ports
//   pclk, presetn        clock, asynchronous active-low reset
//   psel/penable/pwrite  APB control; zero wait states (pready tied high)
//   paddr                register offset, bits [7:2] decoded
//   pwdata/pstrb         write data and byte strobes
//   prdata               combinational read data, 0 when not reading
//   led_o                registered PWM outputs
//
// Register map (word offsets)
//   0x00 CTRL   bit0 EN, bit1 POL (active-low LEDs)
//   0x04 PRESC  [15:0]
//   0x08 PERIOD [7:0]
//   0x0C STATUS read-only, current CNT[7:0]
//   0x10+4*i DUTY_i [7:0]
//
// Build option
//   APB_LED_PSTRB_EN  when defined, honour pstrb per byte; otherwise every
//                     write updates the full word.
module apb_led_pwm #(
   parameter int unsigned PADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned NUM_LED     = 4
) (
   input  logic                    pclk,
   input  logic                    presetn,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [PADDR_WIDTH-1:0]  paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic                    pready,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic [NUM_LED-1:0]      led_o
);

   localparam int unsigned STRB_W   = DATA_WIDTH / 8;
   localparam int unsigned PRESC_W  = 16;
   localparam int unsigned CNT_W    = 8;
   localparam int unsigned CTRL_W   = 2;
   localparam int unsigned IDX_W    = 6;
   localparam int unsigned DUTY_IDX = 4;

   localparam logic [IDX_W-1:0] IDX_CTRL   = 6'd0;
   localparam logic [IDX_W-1:0] IDX_PRESC  = 6'd1;
   localparam logic [IDX_W-1:0] IDX_PERIOD = 6'd2;
   localparam logic [IDX_W-1:0] IDX_STATUS = 6'd3;

   logic [CTRL_W-1:0]  ctrl_q,   ctrl_d;
   logic [PRESC_W-1:0] presc_q,  presc_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic [CNT_W-1:0]   duty_q [NUM_LED];
   logic [CNT_W-1:0]   duty_d [NUM_LED];
   logic [PRESC_W-1:0] pcnt_q,   pcnt_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [NUM_LED-1:0] led_q,    led_d;

   logic [IDX_W-1:0]      addr_idx;
   logic                  wr_en;
   logic                  wr_ctrl, wr_presc, wr_period;
   logic [NUM_LED-1:0]    wr_duty;
   logic [STRB_W-1:0]     byte_en;
   logic [DATA_WIDTH-1:0] wmask;
   logic [CTRL_W-1:0]     ctrl_wval;
   logic [PRESC_W-1:0]    presc_wval;
   logic [CNT_W-1:0]      period_wval;
   logic [CNT_W-1:0]      duty_wval [NUM_LED];
   logic                  tick;
   logic [DATA_WIDTH-1:0] rdata;

   assign addr_idx = paddr[7:2];
   assign wr_en    = psel & penable & pwrite;
   assign pready   = 1'b1;

`ifdef APB_LED_PSTRB_EN
   assign byte_en = pstrb;
   logic unused_ok;
   assign unused_ok = ^{paddr[PADDR_WIDTH-1:8], paddr[1:0]};
`else
   assign byte_en = '1;
   logic unused_ok;
   assign unused_ok = ^{paddr[PADDR_WIDTH-1:8], paddr[1:0], pstrb};
`endif

   // Expand byte enables to a bit mask.
   always_comb begin
      wmask = '0;
      for (int b = 0; b < int'(STRB_W); b++) begin
         wmask[b*8 +: 8] = {8{byte_en[b]}};
      end
   end

   // Merged write values: untouched bytes keep their current contents.
   always_comb begin
      ctrl_wval   = CTRL_W'((DATA_WIDTH'(ctrl_q) & ~wmask) | (pwdata & wmask));
      presc_wval  = PRESC_W'((DATA_WIDTH'(presc_q) & ~wmask) | (pwdata & wmask));
      period_wval = CNT_W'((DATA_WIDTH'(period_q) & ~wmask) | (pwdata & wmask));
      for (int i = 0; i < int'(NUM_LED); i++) begin
         duty_wval[i] = CNT_W'((DATA_WIDTH'(duty_q[i]) & ~wmask) | (pwdata & wmask));
      end
   end

   // Address decode for writes; STATUS and unmapped offsets are ignored.
   always_comb begin
      wr_ctrl   = wr_en && (addr_idx == IDX_CTRL);
      wr_presc  = wr_en && (addr_idx == IDX_PRESC);
      wr_period = wr_en && (addr_idx == IDX_PERIOD);
      wr_duty   = '0;
      for (int i = 0; i < int'(NUM_LED); i++) begin
         wr_duty[i] = wr_en && (addr_idx == IDX_W'(DUTY_IDX + i));
      end
   end

   // Register file next state.
   always_comb begin
      ctrl_d   = ctrl_q;
      presc_d  = presc_q;
      period_d = period_q;
      duty_d   = duty_q;
      if (wr_ctrl)   ctrl_d   = ctrl_wval;
      if (wr_presc)  presc_d  = presc_wval;
      if (wr_period) period_d = period_wval;
      for (int i = 0; i < int'(NUM_LED); i++) begin
         if (wr_duty[i]) duty_d[i] = duty_wval[i];
      end
   end

   // Prescaler and period counter; a restarting write beats a same-cycle tick.
   always_comb begin
      pcnt_d = pcnt_q;
      cnt_d  = cnt_q;
      tick   = ctrl_q[0] && (pcnt_q == presc_q);
      if (wr_presc || wr_period || (wr_ctrl && !ctrl_wval[0]) || !ctrl_q[0]) begin
         pcnt_d = '0;
         cnt_d  = '0;
      end else if (tick) begin
         pcnt_d = '0;
         cnt_d  = (cnt_q >= period_q) ? '0 : cnt_q + CNT_W'(1);
      end else begin
         pcnt_d = pcnt_q + PRESC_W'(1);
      end
   end

   // Compare stage; POL inverts so that EN=0 parks every LED at its off level.
   always_comb begin
      led_d = '0;
      for (int i = 0; i < int'(NUM_LED); i++) begin
         led_d[i] = (ctrl_q[0] & (cnt_q < duty_q[i])) ^ ctrl_q[1];
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         ctrl_q   <= '0;
         presc_q  <= '0;
         period_q <= '0;
         pcnt_q   <= '0;
         cnt_q    <= '0;
         led_q    <= '0;
         for (int i = 0; i < int'(NUM_LED); i++) begin
            duty_q[i] <= '0;
         end
      end else begin
         ctrl_q   <= ctrl_d;
         presc_q  <= presc_d;
         period_q <= period_d;
         pcnt_q   <= pcnt_d;
         cnt_q    <= cnt_d;
         led_q    <= led_d;
         for (int i = 0; i < int'(NUM_LED); i++) begin
            duty_q[i] <= duty_d[i];
         end
      end
   end

   assign led_o = led_q;

   // Read mux, only active during a read transfer.
   always_comb begin
      rdata = '0;
      if (psel && !pwrite) begin
         case (addr_idx)
            IDX_CTRL:   rdata[CTRL_W-1:0]  = ctrl_q;
            IDX_PRESC:  rdata[PRESC_W-1:0] = presc_q;
            IDX_PERIOD: rdata[CNT_W-1:0]   = period_q;
            IDX_STATUS: rdata[CNT_W-1:0]   = cnt_q;
            default: begin
               for (int i = 0; i < int'(NUM_LED); i++) begin
                  if (addr_idx == IDX_W'(DUTY_IDX + i)) rdata[CNT_W-1:0] = duty_q[i];
               end
            end
         endcase
      end
   end

   assign prdata = rdata;

endmodule

// File: doc/apb_led_pwm.md
APB_LED_PWM -- requirements
Module: apb_led_pwm

Interface
REQ-001 SHALL have parameter PADDR_WIDTH, default 16, width of the APB address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of the APB data bus (32 only).
REQ-003 SHALL have parameter NUM_LED, default 4, number of PWM outputs (1..8).
REQ-004 SHALL have port pclk, input, 1 bit: APB clock, the only clock of the block.
REQ-005 SHALL have port presetn, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port psel, input, 1 bit: select, driven from the bridge psel bit 4 (LED slot 0x40040000).
REQ-007 SHALL have port penable, input, 1 bit: APB access phase.
REQ-008 SHALL have port pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port paddr, input, PADDR_WIDTH bits: register offset; only bits [7:2] are decoded.
REQ-010 SHALL have port pwdata, input, DATA_WIDTH bits: write data.
REQ-011 SHALL have port pstrb, input, DATA_WIDTH/8 bits: write byte strobes.
REQ-012 SHALL have port pready, output, 1 bit: transfer complete.
REQ-013 SHALL have port prdata, output, DATA_WIDTH bits: read data.
REQ-014 SHALL have port led_o, output, NUM_LED bits: registered PWM outputs.

Function
REQ-015 SHALL decode the register map as follows. 0x00 CTRL: bit0 EN, bit1 POL (active-low LEDs). 0x04 PRESC[15:0]. 0x08 PERIOD[7:0]. 0x0C STATUS, read-only: {tick count CNT[7:0]}. 0x10+4*i DUTY_i[7:0] for i < NUM_LED.
REQ-016 SHALL drive pready to 1 at all times (zero wait states); there is no error response.
REQ-017 SHALL commit a write on the pclk edge ending the cycle where psel&penable&pwrite=1; the new value SHALL be readable in the next transfer.
REQ-018 SHALL drive prdata combinationally from the addressed register when psel=1 and pwrite=0, with unused bits 0; otherwise it SHALL drive 0.
REQ-019 SHALL ignore writes to unmapped offsets and to STATUS; reads of unmapped offsets SHALL return 0.
REQ-020 SHALL run the 16-bit prescaler counter PCNT 0..PRESC when EN=1 and assert an internal tick when PCNT==PRESC; PCNT SHALL then wrap to 0. PRESC=0 SHALL tick every cycle.
REQ-021 SHALL run the 8-bit counter CNT 0..PERIOD, advancing on each tick and wrapping from PERIOD to 0.
REQ-022 SHALL compute led_o[i] = (EN & (CNT < DUTY_i)) ^ POL, registered one cycle after CNT.
REQ-023 SHALL keep DUTY_i=0 fully off; DUTY_i > PERIOD SHALL be fully on.
REQ-024 SHALL clear PCNT and CNT on the commit edge of any write to PRESC, PERIOD, or to CTRL with EN=0; a write to PRESC or PERIOD SHALL take priority over a simultaneous tick.
REQ-025 SHALL hold PCNT and CNT at 0 while EN=0, with led_o at the off level POL.
REQ-026 SHALL NOT reset counters on a DUTY write; the new duty SHALL apply from the next compare.

Reset
REQ-027 SHALL, on presetn low, asynchronously clear CTRL, PRESC, PERIOD, all DUTY_i, PCNT, CNT and led_o to 0; prdata SHALL be 0 and pready 1.
REQ-028 SHALL drop any in-flight APB write on reset assertion mid-transfer, with no register change after release.

Configuration
REQ-029 SHALL support macro APB_LED_PSTRB_EN. When it is defined, each register byte SHALL be written only if its pstrb bit is 1. When it is undefined, pstrb SHALL be ignored and the full word written.

Verification
REQ-030 Reset scenario: hold presetn low, then release -> reads of CTRL/PRESC/PERIOD/DUTY_0 return 0, led_o=0, pready=1.
REQ-031 PWM scenario: write PRESC=1, PERIOD=3, DUTY_0=2, CTRL=1 -> led_o[0] high 4 pclk and low 4 pclk, repeating (8-cycle period).
REQ-032 Boundary scenario: with PERIOD=3, set DUTY_1=0 and DUTY_2=4, then set CTRL=3 -> led_o[1] constant 1, led_o[2] constant 0.
REQ-033 Restart scenario: while running, write PERIOD=7 -> STATUS reads 0 in the next transfer; the counter then counts 0..7.
REQ-034 Strobe scenario: write 0x00001234 to PRESC with pstrb=4'b0001 -> reads 0x34 with APB_LED_PSTRB_EN defined, 0x1234 without it.
REQ-035 Mid-transfer reset scenario: assert presetn low during a PERIOD write access phase -> PERIOD reads 0 after release.
